// File: rtl/uart_pkg.sv
// Shared definitions for the 8N1 UART receiver and sender.
package uart_pkg;

    // Frame phases common to both directions.
    typedef enum logic [1:0] {
        IDLE,
        START,
        DATA,
        STOP
    } uart_state_t;

    localparam int   DATA_BITS  = 8;
    localparam logic STOP_LEVEL = 1'b1;

    // Rounded integer divisor: clock cycles per period of 'rate' at 'clk_freq'.
    function automatic int unsigned calc_divisor(input int unsigned clk_freq,
                                                 input int unsigned rate);
        return (clk_freq + rate / 2) / rate;
    endfunction

endpackage

// File: rtl/uart_receiver.sv
// 8N1 UART receiver: synchronises the serial line, oversamples the start
// bit to reject glitches, samples data and stop bits at their centres.
module uart_receiver
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16      // must be >= 4
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 rx,
    input  logic                 recv_enable,
    output logic                 recv_finish,
    output logic [DATA_BITS-1:0] readdata
);

    localparam int unsigned TICK_CYC = calc_divisor(CLK_FREQ, BAUD_RATE * OVERSAMPLE);
    localparam int TICK_W = (TICK_CYC > 1) ? $clog2(TICK_CYC) : 1;
    localparam int OS_W   = $clog2(OVERSAMPLE);
    localparam int BIT_W  = $clog2(DATA_BITS);

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(TICK_CYC - 1);
    localparam logic [OS_W-1:0]   OS_LAST   = OS_W'(OVERSAMPLE - 1);
    localparam logic [OS_W-1:0]   HALF_LAST = OS_W'(OVERSAMPLE / 2 - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_BITS - 1);

    logic [1:0]           sync_reg;
    logic                 rx_s;
    logic                 rx_prev_reg;
    logic                 tick;

    uart_state_t          state_reg,    state_next;
    logic [TICK_W-1:0]    tick_cnt_reg, tick_cnt_next;
    logic [OS_W-1:0]      os_cnt_reg,   os_cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg,  bit_cnt_next;
    logic [DATA_BITS-1:0] shift_reg,    shift_next;
    logic [DATA_BITS-1:0] readdata_reg, readdata_next;
    logic                 finish_reg,   finish_next;
    logic                 ferr_reg,     ferr_next;

    assign rx_s        = sync_reg[1];
    assign tick        = (tick_cnt_reg == TICK_LAST);
    assign recv_finish = finish_reg;
    assign readdata    = readdata_reg;

    // Two-flop synchroniser plus a delayed copy for falling-edge detection.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            sync_reg    <= 2'b11;
            rx_prev_reg <= 1'b1;
        end else begin
            sync_reg    <= {sync_reg[0], rx};
            rx_prev_reg <= rx_s;
        end
    end

    // Receiver state and datapath registers.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            state_reg    <= IDLE;
            tick_cnt_reg <= '0;
            os_cnt_reg   <= '0;
            bit_cnt_reg  <= '0;
            shift_reg    <= '0;
            readdata_reg <= '0;
            finish_reg   <= 1'b0;
            ferr_reg     <= 1'b0;
        end else begin
            state_reg    <= state_next;
            tick_cnt_reg <= tick_cnt_next;
            os_cnt_reg   <= os_cnt_next;
            bit_cnt_reg  <= bit_cnt_next;
            shift_reg    <= shift_next;
            readdata_reg <= readdata_next;
            finish_reg   <= finish_next;
            ferr_reg     <= ferr_next;
        end
    end

    // Next-state logic: tick divider, oversample counter and bit sampling.
    always_comb begin
        state_next    = state_reg;
        tick_cnt_next = tick ? '0 : tick_cnt_reg + 1'b1;
        os_cnt_next   = os_cnt_reg;
        bit_cnt_next  = bit_cnt_reg;
        shift_next    = shift_reg;
        readdata_next = readdata_reg;
        finish_next   = 1'b0;
        ferr_next     = ferr_reg;

        case (state_reg)
            IDLE: begin
                // Hold the dividers cleared so each frame starts phase-aligned.
                tick_cnt_next = '0;
                os_cnt_next   = '0;
                bit_cnt_next  = '0;
                ferr_next     = 1'b0;
                if (rx_prev_reg && !rx_s && recv_enable) begin
                    state_next = START;
                end
            end
            START: begin
                if (tick) begin
                    if (os_cnt_reg == HALF_LAST) begin
                        os_cnt_next = '0;
                        // A line back at 1 mid-start-bit was only a glitch.
                        state_next  = rx_s ? IDLE : DATA;
                    end else begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end
                end
            end
            DATA: begin
                if (tick) begin
                    if (os_cnt_reg == OS_LAST) begin
                        os_cnt_next  = '0;
                        shift_next   = {rx_s, shift_reg[DATA_BITS-1:1]};
                        bit_cnt_next = bit_cnt_reg + 1'b1;
                        if (bit_cnt_reg == BIT_LAST) begin
                            state_next = STOP;
                        end
                    end else begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end
                end
            end
            STOP: begin
                if (ferr_reg) begin
                    // Framing error: stay here until the line idles again.
                    if (rx_s == STOP_LEVEL) begin
                        state_next = IDLE;
                    end
                end else if (tick) begin
                    if (os_cnt_reg == OS_LAST) begin
                        os_cnt_next = '0;
                        if (rx_s == STOP_LEVEL) begin
                            readdata_next = shift_reg;
                            finish_next   = 1'b1;
                            state_next    = IDLE;
                        end else begin
                            ferr_next = 1'b1;
                        end
                    end else begin
                        os_cnt_next = os_cnt_reg + 1'b1;
                    end
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_sender.sv
// 8N1 UART sender: on an accepted trigger edge, shifts a latched byte out
// LSB first between a start and a stop bit, each held for one bit period.
module uart_sender
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ  = 100_000_000,
    parameter int unsigned BAUD_RATE = 9600
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic [DATA_BITS-1:0] writedata,
    input  logic                 send_trigger,
    input  logic                 send_enable,
    output logic                 send_work_state,
    output logic                 send_finish,
    output logic                 tx
);

    localparam int unsigned BIT_CYC = calc_divisor(CLK_FREQ, BAUD_RATE);
    localparam int CNT_W = (BIT_CYC > 1) ? $clog2(BIT_CYC) : 1;
    localparam int BIT_W = $clog2(DATA_BITS);

    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(BIT_CYC - 1);
    localparam logic [BIT_W-1:0] BIT_LAST = BIT_W'(DATA_BITS - 1);

    logic trig_prev_reg;
    logic trig_rise;
    logic bit_end;

    uart_state_t          state_reg,   state_next;
    logic [CNT_W-1:0]     cnt_reg,     cnt_next;
    logic [BIT_W-1:0]     bit_cnt_reg, bit_cnt_next;
    logic [DATA_BITS-1:0] data_reg,    data_next;
    logic                 tx_reg,      tx_next;
    logic                 work_reg,    work_next;
    logic                 finish_reg,  finish_next;

    assign trig_rise       = send_trigger & ~trig_prev_reg;
    assign bit_end         = (cnt_reg == CNT_LAST);
    assign tx              = tx_reg;
    assign send_work_state = work_reg;
    assign send_finish     = finish_reg;

    // Sender state, line and trigger-history registers.
    always_ff @(posedge sysclk or negedge reset_n) begin
        if (!reset_n) begin
            trig_prev_reg <= 1'b0;
            state_reg     <= IDLE;
            cnt_reg       <= '0;
            bit_cnt_reg   <= '0;
            data_reg      <= '0;
            tx_reg        <= STOP_LEVEL;
            work_reg      <= 1'b0;
            finish_reg    <= 1'b0;
        end else begin
            trig_prev_reg <= send_trigger;
            state_reg     <= state_next;
            cnt_reg       <= cnt_next;
            bit_cnt_reg   <= bit_cnt_next;
            data_reg      <= data_next;
            tx_reg        <= tx_next;
            work_reg      <= work_next;
            finish_reg    <= finish_next;
        end
    end

    // Next-state logic: bit-period divider and frame sequencing.
    always_comb begin
        state_next   = state_reg;
        cnt_next     = bit_end ? '0 : cnt_reg + 1'b1;
        bit_cnt_next = bit_cnt_reg;
        data_next    = data_reg;
        tx_next      = tx_reg;
        work_next    = work_reg;
        finish_next  = 1'b0;

        case (state_reg)
            IDLE: begin
                cnt_next     = '0;
                bit_cnt_next = '0;
                tx_next      = STOP_LEVEL;
                // Triggers are only looked at here, so busy-time edges are dropped.
                if (trig_rise && send_enable) begin
                    data_next  = writedata;
                    tx_next    = 1'b0;
                    work_next  = 1'b1;
                    state_next = START;
                end
            end
            START: begin
                if (bit_end) begin
                    tx_next    = data_reg[0];
                    data_next  = {1'b0, data_reg[DATA_BITS-1:1]};
                    state_next = DATA;
                end
            end
            DATA: begin
                if (bit_end) begin
                    bit_cnt_next = bit_cnt_reg + 1'b1;
                    if (bit_cnt_reg == BIT_LAST) begin
                        tx_next    = STOP_LEVEL;
                        state_next = STOP;
                    end else begin
                        tx_next   = data_reg[0];
                        data_next = {1'b0, data_reg[DATA_BITS-1:1]};
                    end
                end
            end
            STOP: begin
                if (bit_end) begin
                    work_next   = 1'b0;
                    finish_next = 1'b1;
                    state_next  = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

endmodule

// File: rtl/uart_receiver_sender.sv
// 8N1 UART datapath: independent receiver and sender sharing one clock.
module uart_receiver_sender
    import uart_pkg::*;
#(
    parameter int unsigned CLK_FREQ   = 100_000_000,
    parameter int unsigned BAUD_RATE  = 9600,
    parameter int unsigned OVERSAMPLE = 16      // must be >= 4
) (
    input  logic                 sysclk,
    input  logic                 reset_n,
    input  logic                 UART_RX,
    input  logic                 recv_enable,
    output logic                 recv_finish,
    output logic [DATA_BITS-1:0] readdata,
    input  logic [DATA_BITS-1:0] writedata,
    input  logic                 send_trigger,
    input  logic                 send_enable,
    output logic                 send_work_state,
    output logic                 send_finish,
    output logic                 UART_TX
);

    uart_receiver #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) u_receiver (
        .sysclk      (sysclk),
        .reset_n     (reset_n),
        .rx          (UART_RX),
        .recv_enable (recv_enable),
        .recv_finish (recv_finish),
        .readdata    (readdata)
    );

    uart_sender #(
        .CLK_FREQ  (CLK_FREQ),
        .BAUD_RATE (BAUD_RATE)
    ) u_sender (
        .sysclk          (sysclk),
        .reset_n         (reset_n),
        .writedata       (writedata),
        .send_trigger    (send_trigger),
        .send_enable     (send_enable),
        .send_work_state (send_work_state),
        .send_finish     (send_finish),
        .tx              (UART_TX)
    );

endmodule

// File: tb/tb_uart_receiver_sender.sv
// Self-checking bench for uart_receiver_sender at 16 clocks per bit.
module tb_uart_receiver_sender;

    localparam int unsigned CLK_FREQ   = 1_600_000;
    localparam int unsigned BAUD_RATE  = 100_000;
    localparam int unsigned OVERSAMPLE = 16;
    localparam int          BIT_CYC    = 16;
    localparam int          FRAME_CYC  = 10 * BIT_CYC;

    logic       sysclk       = 1'b0;
    logic       reset_n      = 1'b0;
    logic       rx_drv       = 1'b1;
    logic       loop_en      = 1'b0;
    logic       recv_enable  = 1'b0;
    logic       send_trigger = 1'b0;
    logic       send_enable  = 1'b0;
    logic [7:0] writedata    = 8'h00;
    logic       uart_rx;
    logic       recv_finish;
    logic [7:0] readdata;
    logic       send_work_state;
    logic       send_finish;
    logic       UART_TX;

    int vec_cnt  = 0;
    int err_cnt  = 0;
    int recv_cnt = 0;
    int send_cnt = 0;
    int exp_recv_cnt = 0;
    int exp_send_cnt = 0;
    logic [7:0] exp_readdata = 8'h00;
    logic [7:0] exp_q[$];

    assign uart_rx = loop_en ? UART_TX : rx_drv;

    uart_receiver_sender #(
        .CLK_FREQ   (CLK_FREQ),
        .BAUD_RATE  (BAUD_RATE),
        .OVERSAMPLE (OVERSAMPLE)
    ) dut (
        .sysclk          (sysclk),
        .reset_n         (reset_n),
        .UART_RX         (uart_rx),
        .recv_enable     (recv_enable),
        .recv_finish     (recv_finish),
        .readdata        (readdata),
        .writedata       (writedata),
        .send_trigger    (send_trigger),
        .send_enable     (send_enable),
        .send_work_state (send_work_state),
        .send_finish     (send_finish),
        .UART_TX         (UART_TX)
    );

    always #5 sysclk = ~sysclk;

    task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vec_cnt++;
        if (got !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Pulse counters and received-byte scoreboard.
    always @(negedge sysclk) begin
        if (send_finish) send_cnt++;
        if (recv_finish) begin
            recv_cnt++;
            if (exp_q.size() > 0) check_val("rx_byte", {24'h0, readdata}, {24'h0, exp_q.pop_front()});
            else                  check_val("rx_spurious_pulse", recv_cnt, exp_recv_cnt);
        end
    end

    // Send one byte and compare the line cycle-by-cycle with the ideal frame.
    // Called and returns on a falling edge; returns on the send_finish cycle.
    task automatic tx_frame(input logic [7:0] data, input bit poke);
        logic [9:0] frame;
        int bad_tx;
        int bad_ws;
        frame  = {1'b1, data, 1'b0};
        bad_tx = 0;
        bad_ws = 0;
        writedata    = data;
        send_trigger = 1'b1;
        exp_send_cnt++;
        for (int i = 0; i < FRAME_CYC; i++) begin
            @(negedge sysclk);
            if (i == 1) send_trigger = 1'b0;
            if (poke) begin
                if (i == 40) send_trigger = 1'b1;
                if (i == 42) send_trigger = 1'b0;
                if (i == 60) writedata = ~data;
            end
            if (UART_TX !== frame[i / BIT_CYC]) bad_tx++;
            if (send_work_state !== 1'b1) bad_ws++;
        end
        @(negedge sysclk);
        check_val("tx_wave_bad_cycles", bad_tx, 0);
        check_val("tx_busy_bad_cycles", bad_ws, 0);
        check_val("tx_end_finish_busy", {30'h0, send_finish, send_work_state}, 32'h2);
        $display("tx byte %02h poke %0b: bad line cycles %0d", data, poke, bad_tx);
    endtask

    // Drive one frame onto the receive line; model decides if it should land.
    task automatic rx_frame(input logic [7:0] data, input logic stop_bit);
        logic [9:0] frame;
        frame = {stop_bit, data, 1'b0};
        if (recv_enable && stop_bit) begin
            exp_q.push_back(data);
            exp_readdata = data;
            exp_recv_cnt++;
        end
        for (int b = 0; b < 10; b++) begin
            rx_drv = frame[b];
            repeat (BIT_CYC) @(negedge sysclk);
        end
        rx_drv = 1'b1;
        repeat (2 * BIT_CYC) @(negedge sysclk);
        check_val("rx_readdata", {24'h0, readdata}, {24'h0, exp_readdata});
        check_val("rx_pulse_count", recv_cnt, exp_recv_cnt);
        $display("rx byte %02h stop %0b enable %0b -> readdata %02h", data, stop_bit, recv_enable, readdata);
    endtask

    initial begin
        logic [7:0] loop_bytes [4];
        int bad;
        loop_bytes[0] = 8'h00;
        loop_bytes[1] = 8'hFF;
        loop_bytes[2] = 8'h55;
        loop_bytes[3] = 8'h81;

        // Reset values.
        repeat (3) @(negedge sysclk);
        check_val("rst_uart_tx", {31'h0, UART_TX}, 1);
        check_val("rst_readdata", {24'h0, readdata}, 0);
        check_val("rst_recv_finish", {31'h0, recv_finish}, 0);
        check_val("rst_send_finish", {31'h0, send_finish}, 0);
        check_val("rst_work_state", {31'h0, send_work_state}, 0);
        reset_n = 1'b1;
        send_enable = 1'b1;
        recv_enable = 1'b1;
        repeat (2) @(negedge sysclk);

        // Directed TX and RX.
        tx_frame(8'hA5, 1'b0);
        @(negedge sysclk);
        check_val("tx_finish_one_cycle", {31'h0, send_finish}, 0);
        rx_frame(8'h3C, 1'b1);
        recv_enable = 1'b0;
        rx_frame(8'h5A, 1'b1);
        recv_enable = 1'b1;

        // Framing error, idle-line glitch, then a clean frame.
        rx_frame(8'hC3, 1'b0);
        rx_drv = 1'b0;
        repeat (4) @(negedge sysclk);
        rx_drv = 1'b1;
        repeat (3 * BIT_CYC) @(negedge sysclk);
        check_val("glitch_pulse_count", recv_cnt, exp_recv_cnt);
        check_val("glitch_readdata", {24'h0, readdata}, {24'h0, exp_readdata});
        rx_frame(8'h96, 1'b1);

        // Ignored triggers: while busy, and with send_enable low.
        tx_frame(8'h4B, 1'b1);
        send_enable = 1'b0;
        bad = 0;
        for (int i = 0; i < 12 * BIT_CYC; i++) begin
            if (i == 2) send_trigger = 1'b1;
            if (i == 4) send_trigger = 1'b0;
            @(negedge sysclk);
            if (UART_TX !== 1'b1 || send_work_state !== 1'b0) bad++;
        end
        check_val("tx_disabled_bad_cycles", bad, 0);
        check_val("tx_finish_count", send_cnt, exp_send_cnt);
        send_enable = 1'b1;

        // Reset in the middle of a TX frame.
        writedata = 8'h00;
        send_trigger = 1'b1;
        repeat (2) @(negedge sysclk);
        send_trigger = 1'b0;
        repeat (40) @(negedge sysclk);
        check_val("midframe_tx_low", {31'h0, UART_TX}, 0);
        reset_n = 1'b0;
        #1;
        check_val("abort_uart_tx", {31'h0, UART_TX}, 1);
        check_val("abort_work_state", {31'h0, send_work_state}, 0);
        exp_readdata = 8'h00;
        exp_q.delete();
        @(negedge sysclk);
        reset_n = 1'b1;
        bad = 0;
        for (int i = 0; i < 12 * BIT_CYC; i++) begin
            @(negedge sysclk);
            if (UART_TX !== 1'b1) bad++;
        end
        check_val("abort_line_low_cycles", bad, 0);
        check_val("abort_finish_count", send_cnt, exp_send_cnt);
        check_val("abort_readdata", {24'h0, readdata}, 0);

        // Loopback, back-to-back frames.
        loop_en = 1'b1;
        foreach (loop_bytes[k]) begin
            exp_q.push_back(loop_bytes[k]);
            exp_readdata = loop_bytes[k];
            exp_recv_cnt++;
            tx_frame(loop_bytes[k], 1'b0);
        end
        repeat (2 * BIT_CYC) @(negedge sysclk);
        check_val("loop_readdata", {24'h0, readdata}, {24'h0, exp_readdata});
        check_val("loop_pulse_count", recv_cnt, exp_recv_cnt);
        loop_en = 1'b0;

        // Randomized RX frames (enable and stop bit varied) and TX frames.
        for (int n = 0; n < 8; n++) begin
            recv_enable = ($urandom_range(0, 3) != 0);
            rx_frame(8'($urandom), ($urandom_range(0, 4) != 0));
        end
        recv_enable = 1'b1;
        for (int n = 0; n < 5; n++) begin
            repeat ($urandom_range(0, 20)) @(negedge sysclk);
            tx_frame(8'($urandom), bit'($urandom_range(0, 1)));
        end

        repeat (4) @(negedge sysclk);
        check_val("final_send_count", send_cnt, exp_send_cnt);
        check_val("final_recv_count", recv_cnt, exp_recv_cnt);
        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

endmodule
